// File: rtl/bht_updater.sv
// bht_updater: training side of the branch history table.
//
// Resolved-branch reports from execute are buffered in a small FIFO and
// processed one at a time. A shadow tag array plus a 2-bit hysteresis
// counter per BHT index decide when the BHT entry is (re)written, so that
// a BHT hit means "predict taken". A flush request sweeps the whole BHT
// to the INVALID (all-ones) tag.
//
// Ports:
//   clk_in          clock (BHT samples writes on the falling edge)
//   rst_n_in        asynchronous active-low reset
//   res_valid_in    resolved branch report valid
//   res_ready_out   updater accepts a report this cycle
//   res_pc_in       PC of the resolved branch
//   res_taken_in    branch outcome (1 = taken)
//   flush_in        single-cycle pulse: invalidate the whole BHT
//   bht_write_out   BHT write strobe (registered)
//   bht_index_out   BHT write index (registered, holds between writes)
//   bht_tag_out     BHT write tag (registered, holds between writes)
//   busy_out        FIFO non-empty or FSM not idle
//   dbg_state_out   current FSM state (IDLE=0, LOAD=1, COMMIT=2, FLUSH=3)
//
// Handshake: a report transfers on a rising edge where res_valid_in and
// res_ready_out are both high; res_pc_in/res_taken_in are sampled only
// then. res_ready_out depends on FIFO-full (not on a same-cycle pop), the
// FLUSH state and flush_in, never on res_valid_in.
module bht_updater #(
  parameter int TAG   = 27,
  parameter int PC    = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              res_valid_in,
  output logic              res_ready_out,
  input  logic [PC-1:0]     res_pc_in,
  input  logic              res_taken_in,
  input  logic              flush_in,
  output logic              bht_write_out,
  output logic [PC-TAG-1:0] bht_index_out,
  output logic [TAG-1:0]    bht_tag_out,
  output logic              busy_out,
  output logic [1:0]        dbg_state_out
);

  localparam int IW      = PC - TAG;
  localparam int ENTRIES = 1 << IW;
  localparam int PW      = $clog2(DEPTH);
  localparam logic [TAG-1:0] INVALID  = '1;
  localparam logic [IW-1:0]  LAST_IDX = '1;
  localparam logic [IW-1:0]  IDX_ONE  = 1;
  localparam logic [PW:0]    PTR_ONE  = 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, COMMIT = 2'd2, FLUSH = 2'd3} state_e;
  state_e state_q, state_d;

  // Resolution FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [PC-1:0]    fifo_pc_q [DEPTH];
  logic [DEPTH-1:0] fifo_tk_q;
  logic [PW:0]      wr_ptr_q, rd_ptr_q;
  logic             fifo_empty, fifo_full, push, pop, fifo_clr;
  logic [PC-1:0]    head_pc;

  // Report being processed.
  logic [IW-1:0]  wk_idx_q;
  logic [TAG-1:0] wk_tag_q;
  logic           wk_taken_q;

  // Shadow of the BHT plus hysteresis counters.
  logic [TAG-1:0] shadow_q [ENTRIES];
  logic [1:0]     ctr_q    [ENTRIES];

  // Update decided in LOAD, applied to the shadow arrays in COMMIT.
  logic           cm_upd_q, cm_upd_d;
  logic [1:0]     cm_ctr_q, cm_ctr_d;
  logic [TAG-1:0] cm_tag_q, cm_tag_d;
  logic           wr_req;
  logic [TAG-1:0] wr_tag;
  logic [TAG-1:0] sh_tag;
  logic [1:0]     old_ctr;

  logic [IW-1:0]  sweep_q, sweep_d;
  logic           pend_q, pend_d;
  logic           bw_q, bw_d;
  logic [IW-1:0]  bi_q, bi_d;
  logic [TAG-1:0] bt_q, bt_d;

  assign fifo_empty    = (wr_ptr_q == rd_ptr_q);
  assign fifo_full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                         (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_pc       = fifo_pc_q[rd_ptr_q[PW-1:0]];
  assign res_ready_out = !fifo_full && (state_q != FLUSH) && !flush_in;
  assign push          = res_valid_in && res_ready_out;
  assign busy_out      = !fifo_empty || (state_q != IDLE);
  assign dbg_state_out = state_q;
  assign bht_write_out = bw_q;
  assign bht_index_out = bi_q;
  assign bht_tag_out   = bt_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (fifo_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // FIFO payload needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q[PW-1:0]] <= res_pc_in;
      fifo_tk_q[wr_ptr_q[PW-1:0]] <= res_taken_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wk_idx_q   <= '0;
      wk_tag_q   <= '0;
      wk_taken_q <= 1'b0;
    end else if (pop) begin
      wk_idx_q   <= head_pc[IW-1:0];
      wk_tag_q   <= head_pc[PC-1:IW];
      wk_taken_q <= fifo_tk_q[rd_ptr_q[PW-1:0]];
    end
  end

  // Training rules. The write decision is made in LOAD and registered so the
  // strobe is visible during COMMIT, when the BHT samples it on the falling edge.
  assign sh_tag  = shadow_q[wk_idx_q];
  assign old_ctr = ctr_q[wk_idx_q];

  always_comb begin
    cm_upd_d = 1'b0;
    cm_ctr_d = old_ctr;
    cm_tag_d = sh_tag;
    wr_req   = 1'b0;
    wr_tag   = wk_tag_q;
    // An all-ones tag would alias the empty encoding; such branches are ignored.
    if (wk_tag_q != INVALID) begin
      if (sh_tag == wk_tag_q) begin
        cm_upd_d = 1'b1;
        if (wk_taken_q) begin
          cm_ctr_d = (old_ctr == 2'd3) ? 2'd3 : old_ctr + 2'd1;
          wr_req   = (old_ctr == 2'd1);
        end else begin
          cm_ctr_d = (old_ctr == 2'd0) ? 2'd0 : old_ctr - 2'd1;
          wr_req   = (old_ctr == 2'd2);
          wr_tag   = INVALID;
        end
      end else if (wk_taken_q) begin
        cm_upd_d = 1'b1;
        cm_tag_d = wk_tag_q;
        cm_ctr_d = 2'd2;
        wr_req   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cm_upd_q <= 1'b0;
      cm_ctr_q <= '0;
      cm_tag_q <= '0;
    end else if (state_q == LOAD) begin
      cm_upd_q <= cm_upd_d;
      cm_ctr_q <= cm_ctr_d;
      cm_tag_q <= cm_tag_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        shadow_q[i] <= INVALID;
        ctr_q[i]    <= '0;
      end
    end else if (state_q == FLUSH) begin
      shadow_q[sweep_q] <= INVALID;
      ctr_q[sweep_q]    <= '0;
    end else if ((state_q == COMMIT) && cm_upd_q) begin
      shadow_q[wk_idx_q] <= cm_tag_q;
      ctr_q[wk_idx_q]    <= cm_ctr_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      sweep_q <= '0;
      pend_q  <= 1'b0;
      bw_q    <= 1'b0;
      bi_q    <= '0;
      bt_q    <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      pend_q  <= pend_d;
      bw_q    <= bw_d;
      bi_q    <= bi_d;
      bt_q    <= bt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    pend_d   = pend_q;
    bw_d     = 1'b0;
    bi_d     = bi_q;
    bt_d     = bt_q;
    pop      = 1'b0;
    fifo_clr = 1'b0;
    case (state_q)
      IDLE: begin
        // A flush (fresh or held over from LOAD/COMMIT) beats a pop and
        // discards every queued report.
        if (flush_in || pend_q) begin
          state_d  = FLUSH;
          fifo_clr = 1'b1;
          pend_d   = 1'b0;
          sweep_d  = '0;
          bw_d     = 1'b1;
          bi_d     = '0;
          bt_d     = INVALID;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (flush_in) pend_d = 1'b1;
        state_d = COMMIT;
        bw_d    = wr_req;
        if (wr_req) begin
          bi_d = wk_idx_q;
          bt_d = wr_tag;
        end
      end
      COMMIT: begin
        if (flush_in) pend_d = 1'b1;
        state_d = IDLE;
      end
      FLUSH: begin
        // sweep_q is the index being written this cycle; the next one is
        // prepared for the following cycle.
        if (sweep_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          sweep_d = sweep_q + IDX_ONE;
          bw_d    = 1'b1;
          bi_d    = sweep_q + IDX_ONE;
          bt_d    = INVALID;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bht_updater.sv
// Testbench for bht_updater (TAG=27, PC=32, DEPTH=4, 32 BHT entries).
module tb_bht_updater;

  localparam logic [26:0] INV = '1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        res_valid = 1'b0;
  logic        res_taken = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] res_pc = '0;
  logic        res_ready, bht_write, busy;
  logic [4:0]  bht_index;
  logic [26:0] bht_tag;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int fails   = 0;
  int wr_seen = 0;

  // Expected BHT writes in order: {index[4:0], tag[26:0]}.
  logic [31:0] exp_q[$];
  logic [31:0] cmp_e;
  logic [4:0]  last_idx = '0;
  logic [26:0] last_tag = '0;

  // Behavioural model of the training tables.
  int          m_ctr [32];
  logic [26:0] m_tag [32];

  bht_updater #(.TAG(27), .PC(32), .DEPTH(4)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .res_valid_in  (res_valid),
    .res_ready_out (res_ready),
    .res_pc_in     (res_pc),
    .res_taken_in  (res_taken),
    .flush_in      (flush),
    .bht_write_out (bht_write),
    .bht_index_out (bht_index),
    .bht_tag_out   (bht_tag),
    .busy_out      (busy),
    .dbg_state_out (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_ctr[i] = 0;
      m_tag[i] = INV;
    end
  endtask

  task automatic model_apply(input logic [31:0] pc, input bit tk);
    logic [4:0]  idx;
    logic [26:0] tag;
    idx = pc[4:0];
    tag = pc[31:5];
    if (tag != INV) begin
      if (m_tag[idx] == tag) begin
        if (tk) begin
          if (m_ctr[idx] == 1) exp_q.push_back({idx, tag});
          if (m_ctr[idx] < 3) m_ctr[idx] = m_ctr[idx] + 1;
        end else begin
          if (m_ctr[idx] == 2) exp_q.push_back({idx, INV});
          if (m_ctr[idx] > 0) m_ctr[idx] = m_ctr[idx] - 1;
        end
      end else if (tk) begin
        m_tag[idx] = tag;
        m_ctr[idx] = 2;
        exp_q.push_back({idx, tag});
      end
    end
  endtask

  task automatic model_flush();
    logic [4:0] ii;
    for (int i = 0; i < 32; i++) begin
      ii = 5'(i);
      m_ctr[i] = 0;
      m_tag[i] = INV;
      exp_q.push_back({ii, INV});
    end
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bht_write) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          cmp_e = exp_q.pop_front();
          check("wr_index", 32'(bht_index), 32'(cmp_e[31:27]));
          check("wr_tag", 32'(bht_tag), 32'(cmp_e[26:0]));
          last_idx = cmp_e[31:27];
          last_tag = cmp_e[26:0];
        end
      end else begin
        check("hold_index", 32'(bht_index), 32'(last_idx));
        check("hold_tag", 32'(bht_tag), 32'(last_tag));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n     = 1'b0;
    res_valid = 1'b0;
    flush     = 1'b0;
    exp_q.delete();
    model_clear();
    last_idx = '0;
    last_tag = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(res_ready), 32'd1);
    check("rst_write", 32'(bht_write), 32'd0);
    check("rst_index", 32'(bht_index), 32'd0);
    check("rst_tag", 32'(bht_tag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Offer one report until accepted; returns 1 time unit after the push edge.
  task automatic send(input logic [31:0] pc, input bit tk, input bit modeled);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    res_valid = 1'b1;
    res_pc    = pc;
    res_taken = tk;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = res_ready;
      @(posedge clk); #1;
      n++;
    end
    res_valid = 1'b0;
    check("push_accept", 32'(acc), 32'd1);
    if (acc && modeled) model_apply(pc, tk);
  endtask

  task automatic wait_idle();
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
      n++;
    end
    check("idle_timeout", 32'(done), 32'd1);
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    model_flush();
    @(negedge clk);
    check("flush_req_ready", 32'(res_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int nacc;
    bit saw_low;
    bit found;
    int n;

    model_clear();

    // Allocate, then decay with two not-taken reports.
    do_reset();
    base = wr_seen;
    send(32'h0000_0043, 1'b1, 1'b1);
    @(negedge clk);
    check("t1_pop_cycle_write", 32'(bht_write), 32'd0);
    check("t1_pop_cycle_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_load_write", 32'(bht_write), 32'd0);
    @(negedge clk);
    check("t1_commit_write", 32'(bht_write), 32'd1);
    check("t1_commit_index", 32'(bht_index), 32'h03);
    check("t1_commit_tag", 32'(bht_tag), 32'h0000002);
    @(posedge clk); #1;
    send(32'h0000_0043, 1'b0, 1'b1);
    send(32'h0000_0043, 1'b0, 1'b1);
    wait_idle();
    check("t1_write_count", 32'(wr_seen - base), 32'd2);
    check("t1_hold_tag_invalid", 32'(bht_tag), 32'h7FFFFFF);
    check("t1_model_ctr", 32'(m_ctr[3]), 32'd0);

    // Saturation: four taken -> one write, then not-taken -> no write.
    do_reset();
    base = wr_seen;
    for (int k = 0; k < 4; k++) send(32'h0000_0043, 1'b1, 1'b1);
    wait_idle();
    check("sat_write_count", 32'(wr_seen - base), 32'd1);
    check("sat_model_ctr", 32'(m_ctr[3]), 32'd3);
    send(32'h0000_0043, 1'b0, 1'b1);
    wait_idle();
    check("sat_nt_write_count", 32'(wr_seen - base), 32'd1);
    check("sat_nt_model_ctr", 32'(m_ctr[3]), 32'd2);

    // All-ones tag is never allocated.
    send(32'hFFFF_FFE3, 1'b1, 1'b1);
    wait_idle();
    check("inv_tag_write_count", 32'(wr_seen - base), 32'd1);

    // Alias on index 3.
    do_reset();
    base = wr_seen;
    send(32'h0000_0043, 1'b1, 1'b1);
    send(32'h0000_0063, 1'b1, 1'b1);
    wait_idle();
    check("alias_write_count", 32'(wr_seen - base), 32'd2);
    check("alias_hold_index", 32'(bht_index), 32'h03);
    check("alias_hold_tag", 32'(bht_tag), 32'h0000003);
    send(32'h0000_0043, 1'b0, 1'b1);
    wait_idle();
    check("alias_nt_write_count", 32'(wr_seen - base), 32'd2);

    // Back-to-back valid for 10 cycles into an idle, empty updater.
    do_reset();
    base = wr_seen;
    nacc = 0;
    saw_low = 1'b0;
    for (int c = 0; c < 10; c++) begin
      res_valid = 1'b1;
      res_taken = 1'b1;
      res_pc    = {27'(nacc + 1), 5'(nacc)};
      @(negedge clk);
      if (res_ready) begin
        model_apply(res_pc, 1'b1);
        nacc++;
      end else begin
        saw_low = 1'b1;
      end
      @(posedge clk); #1;
    end
    res_valid = 1'b0;
    check("b2b_accepted", 32'(nacc), 32'd7);
    check("b2b_ready_dropped", 32'(saw_low), 32'd1);
    wait_idle();
    check("b2b_write_count", 32'(wr_seen - base), 32'd7);

    // Flush requested during COMMIT with two reports queued.
    do_reset();
    send(32'h0000_0045, 1'b1, 1'b1);
    send(32'h0000_0046, 1'b1, 1'b0);
    send(32'h0000_0047, 1'b1, 1'b0);
    pulse_flush();
    found = 1'b0;
    n = 0;
    while (!found && n < 10) begin
      @(negedge clk);
      if (bht_write) found = 1'b1;
      n++;
    end
    check("flush_start", 32'(found), 32'd1);
    for (int j = 0; j < 32; j++) begin
      if (j > 0) @(negedge clk);
      check("flush_write", 32'(bht_write), 32'd1);
      check("flush_ready", 32'(res_ready), 32'd0);
    end
    @(negedge clk);
    check("flush_end_write", 32'(bht_write), 32'd0);
    @(posedge clk); #1;
    wait_idle();

    // Reset in the middle of a sweep.
    pulse_flush();
    found = 1'b0;
    n = 0;
    while (!found && n < 40) begin
      @(negedge clk);
      if (bht_write && bht_index == 5'd10) found = 1'b1;
      n++;
    end
    check("sweep_reach_10", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    model_clear();
    last_idx = '0;
    last_tag = '0;
    #1;
    check("mid_rst_write", 32'(bht_write), 32'd0);
    check("mid_rst_ready", 32'(res_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_index", 32'(bht_index), 32'd0);
    @(negedge clk);
    check("mid_rst_held_write", 32'(bht_write), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = wr_seen;
    send(32'h0000_0043, 1'b1, 1'b1);
    wait_idle();
    check("post_rst_write_count", 32'(wr_seen - base), 32'd1);

    check("final_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
